slc_readback_serializer: RTL and testbench
==========================================

Name: slc_readback_serializer

Overview:
- Readback unloader for a super logic cell: on request, snapshots the cell's registered outputs (AQZ lanes plus carry-out) and streams them out serially, LSB first, over a valid/ready bit interface.
- Sits beside each super logic cell and feeds the configuration/debug scan path.
- Write side is the logic cells' flops; this block is the read side.

Parameters:
- LANES, 8, number of AQZ lanes captured. Frame length is LANES+1 bits (lanes plus CO).
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- QCK  input  1  clock; all flops rise-edge.
- QRT  input  1  asynchronous active-high reset.
- QEN  input  1  global enable; when 0, all state holds.
- CAP  input  1  capture request, sampled on QCK when QEN=1.
- AQZ_IN  input  LANES  registered lane outputs to snapshot.
- CO_IN  input  1  carry-chain output to snapshot.
- SREADY  input  1  downstream ready for current bit.
- OVR_CLR  input  1  synchronous clear of the overrun counter.
- SDO  output  1  serial data bit.
- SVALID  output  1  SDO valid.
- SSOF  output  1  first bit of frame (AQZ[0]).
- SEOF  output  1  last bit of frame (CO).
- BUSY  output  1  frame in progress.
- DONE  output  1  one-cycle pulse after last bit transferred.
- OVR_CNT  output  OVR_W  count of dropped capture requests.

Behaviour:
- Reset (QRT=1, asynchronous):
  - Outputs SDO, SVALID, SSOF, SEOF, BUSY, DONE = 0; OVR_CNT = 0.
  - Shift register = 0; bit counter = 0; state = IDLE.
  - Reset mid-frame aborts the frame; no DONE.
- Frame: snapshot S = {CO_IN, AQZ_IN}, LANES+1 bits. Bit k is sent at counter k. AQZ_IN[0] is sent first, CO_IN last.
- Shift register: SDO = shreg[0]. Each transfer shifts right by one and fills the MSB with 0.
- Outputs decoded from registered state: SVALID = BUSY = (state==SHIFT); SSOF = SHIFT && cnt==0; SEOF = SHIFT && cnt==LANES.
- State IDLE:
  - CAP=1 and QEN=1: at that edge, shreg <= S, cnt <= 0, state <= SHIFT.
  - SVALID rises the following cycle, so capture-to-first-bit latency is 1 cycle.
- State SHIFT:
  - A transfer occurs on an edge with SVALID && SREADY && QEN. Each transfer: shift, cnt++.
  - SVALID stays high while SREADY=0 and SDO/SSOF/SEOF are stable (no drop, no change).
  - Transfer at cnt==LANES is the last bit. Next cycle: state=IDLE, DONE=1 for exactly one cycle.
  - Last transfer together with CAP=1: the new snapshot is loaded, cnt=0, state stays SHIFT, and DONE still pulses. This gives back-to-back frames with no idle gap.
  - CAP=1 in SHIFT in any other cycle: request dropped; OVR_CNT increments, saturating at 2^OVR_W-1.
- OVR_CLR=1: OVR_CNT <= 0. If OVR_CLR and an overrun occur in the same cycle, the clear wins (result 0).
- QEN=0:
  - No state, counter, shreg, or OVR_CNT change.
  - CAP is ignored and not counted.
  - SREADY is ignored (no transfer).
  - DONE, if high, holds until the next QEN=1 edge.
  - OVR_CLR is also gated by QEN.
- Throughput: maximum one bit per cycle. A frame takes LANES+1 transfer cycles plus 1 capture cycle.

Test Plan:
- Basic frame: AQZ_IN=8'hA5, CO_IN=1, pulse CAP, SREADY=1 -> SVALID high 9 cycles starting 1 cycle after CAP; SDO sequence 1,0,1,0,0,1,0,1,1; SSOF on bit0, SEOF on bit8; DONE one cycle after bit8; BUSY then 0.
- Backpressure: same frame, SREADY toggled 0/1 each cycle -> identical bit sequence over 18 cycles; SDO stable whenever SREADY=0; no lost or duplicated bits.
- Overrun: CAP held high for the whole 9-bit frame -> the capture at bit8 is accepted as a back-to-back frame (no gap); the 8 mid-frame CAP cycles give OVR_CNT=8. Then OVR_CLR together with CAP mid-frame -> OVR_CNT=0.
- Saturation: OVR_W=2, force 5 overruns -> OVR_CNT=3.
- QEN gating: QEN=0 for 4 cycles mid-frame with SREADY=1 and CAP=1 -> counter frozen, SDO held, OVR_CNT unchanged; the frame resumes correctly once QEN=1.
- Async reset: assert QRT at bit 4 between clock edges -> SVALID/BUSY drop immediately; no DONE; after release with AQZ_IN=8'h3C, CO_IN=0 and CAP pulsed -> clean frame 0,0,1,1,1,1,0,0,0.

Source files
------------

// File: rtl/slc_readback_serializer.sv
// slc_readback_serializer: snapshots a super logic cell's AQZ lanes plus CO
// and streams them LSB first over a valid/ready serial interface.
module slc_readback_serializer #(
    parameter int LANES = 8,
    parameter int OVR_W = 8
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             QEN,
    input  logic             CAP,
    input  logic [LANES-1:0] AQZ_IN,
    input  logic             CO_IN,
    input  logic             SREADY,
    input  logic             OVR_CLR,
    output logic             SDO,
    output logic             SVALID,
    output logic             SSOF,
    output logic             SEOF,
    output logic             BUSY,
    output logic             DONE,
    output logic [OVR_W-1:0] OVR_CNT
);
    localparam int CW = $clog2(LANES + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t         state, state_n;
    logic [LANES:0] shreg, shreg_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           done_n, xfer, last, cap_ok, overrun;
    logic [OVR_W-1:0] ovr_n;
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            DONE    <= 1'b0;
            OVR_CNT <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            DONE    <= done_n;
            OVR_CNT <= ovr_n;
        end
    end
    // A capture coinciding with the last transfer chains frames back to back.
    always_comb begin
        xfer    = (state == SHIFT) && SREADY && QEN;
        last    = xfer && (cnt == CW'(LANES));
        cap_ok  = QEN && CAP && ((state == IDLE) || last);
        overrun = QEN && CAP && (state == SHIFT) && !last;
        state_n = cap_ok ? SHIFT : last ? IDLE : state;
        shreg_n = cap_ok ? {CO_IN, AQZ_IN} : xfer ? (shreg >> 1) : shreg;
        cnt_n   = cap_ok ? '0 : xfer ? cnt + 1'b1 : cnt;
        done_n  = QEN ? last : DONE;
        ovr_n   = !QEN ? OVR_CNT :
                  OVR_CLR ? '0 :
                  (overrun && OVR_CNT != {OVR_W{1'b1}}) ? OVR_CNT + 1'b1 : OVR_CNT;
    end
    always_comb begin
        SDO    = shreg[0];
        SVALID = (state == SHIFT);
        BUSY   = (state == SHIFT);
        SSOF   = (state == SHIFT) && (cnt == '0);
        SEOF   = (state == SHIFT) && (cnt == CW'(LANES));
    end
endmodule

// File: tb/tb_slc_readback_serializer.sv
// tb_slc_readback_serializer: directed checks of framing, backpressure,
// overrun counting/saturation, enable gating and asynchronous reset.
module tb_slc_readback_serializer;
    logic       clk = 0, rst, qen, cap, co, sready, clr;
    logic [7:0] aqz;
    logic       sdo, svalid, ssof, seof, busy, done;
    logic [7:0] ovr;
    logic       sdo2, svalid2, ssof2, seof2, busy2, done2;
    logic [1:0] ovr2;
    int total = 0, bad = 0;

    slc_readback_serializer #(.LANES(8), .OVR_W(8)) dut (
        .QCK(clk), .QRT(rst), .QEN(qen), .CAP(cap), .AQZ_IN(aqz), .CO_IN(co),
        .SREADY(sready), .OVR_CLR(clr), .SDO(sdo), .SVALID(svalid), .SSOF(ssof),
        .SEOF(seof), .BUSY(busy), .DONE(done), .OVR_CNT(ovr));

    slc_readback_serializer #(.LANES(8), .OVR_W(2)) dut2 (
        .QCK(clk), .QRT(rst), .QEN(qen), .CAP(cap), .AQZ_IN(aqz), .CO_IN(co),
        .SREADY(sready), .OVR_CLR(clr), .SDO(sdo2), .SVALID(svalid2), .SSOF(ssof2),
        .SEOF(seof2), .BUSY(busy2), .DONE(done2), .OVR_CNT(ovr2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // exp holds the frame bits in transmit order: exp[0] goes out first.
    task automatic run_frame(input logic [7:0] a, input logic c, input logic [8:0] exp, input logic bp);
        aqz = a; co = c; cap = 1; sready = 1;
        step();
        cap = 0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("sdo[%0d]", k), sdo, exp[k]);
            chk($sformatf("svalid[%0d]", k), svalid, 1);
            chk($sformatf("ssof[%0d]", k), ssof, k == 0);
            chk($sformatf("seof[%0d]", k), seof, k == 8);
            chk($sformatf("done_mid[%0d]", k), done, 0);
            if (bp) begin
                sready = 0;
                step();
                chk($sformatf("bp_sdo[%0d]", k), sdo, exp[k]);
                chk($sformatf("bp_valid[%0d]", k), svalid, 1);
                chk($sformatf("bp_sof[%0d]", k), ssof, k == 0);
                sready = 1;
            end
            step();
        end
        chk("frame_done", done, 1);
        chk("frame_busy", busy, 0);
        chk("frame_valid", svalid, 0);
        step();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        rst = 1; qen = 1; cap = 0; co = 0; sready = 0; clr = 0; aqz = 0;
        #12;
        chk("rst_sdo", sdo, 0);
        chk("rst_valid", svalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sof_eof", {ssof, seof}, 0);
        chk("rst_ovr", ovr, 0);
        rst = 0;
        step();

        // A5 with CO=1 -> 1,0,1,0,0,1,0,1,1
        run_frame(8'hA5, 1'b1, 9'b1_1010_0101, 1'b0);
        run_frame(8'hA5, 1'b1, 9'b1_1010_0101, 1'b1);

        // CAP held through a whole frame: 8 drops, then a back-to-back reload
        aqz = 8'hA5; co = 1; cap = 1; sready = 1;
        step();
        for (int k = 0; k < 9; k++) step();
        chk("ovr_count", ovr, 8);
        chk("ovr_sat", ovr2, 3);
        chk("b2b_done", done, 1);
        chk("b2b_valid", svalid, 1);
        chk("b2b_sof", ssof, 1);
        clr = 1;
        step();
        chk("ovr_clr", ovr, 0);
        chk("ovr_clr2", ovr2, 0);
        clr = 0; cap = 0;
        for (int k = 0; k < 20 && busy; k++) step();
        chk("drain_busy", busy, 0);
        chk("drain_done", done, 1);
        step();

        // QEN gating mid-frame
        aqz = 8'h5A; co = 0; cap = 1; sready = 1;
        step();
        cap = 0;
        step(); step();
        chk("gate_pre_sdo", sdo, 0);
        qen = 0; cap = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("gate_sdo", sdo, 0);
            chk("gate_valid", svalid, 1);
            chk("gate_sof", ssof, 0);
            chk("gate_ovr", ovr, 0);
        end
        qen = 1; cap = 0;
        // 5A, CO=0 -> 0,1,0,1,1,0,1,0,0; bits 2..8 remain
        for (int k = 2; k < 9; k++) begin
            chk($sformatf("gate_bit[%0d]", k), sdo, (9'b0_0101_1010 >> k) & 1);
            chk($sformatf("gate_eof[%0d]", k), seof, k == 8);
            step();
        end
        chk("gate_done", done, 1);
        qen = 0;
        step();
        chk("gate_done_hold", done, 1);
        qen = 1;
        step();
        chk("gate_done_clear", done, 0);

        // Async reset at bit 4
        aqz = 8'hA5; co = 1; cap = 1; sready = 1;
        step();
        cap = 0;
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_valid", svalid, 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", svalid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        step();
        rst = 0;
        step();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        // 3C, CO=0 -> 0,0,1,1,1,1,0,0,0
        run_frame(8'h3C, 1'b0, 9'b0_0011_1100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
